// File: rtl/rr_arbiter_burst.sv
// N-way round-robin arbiter with burst holding and registered grant outputs.
// The owner keeps the grant up to MAX_BURST cycles; on release the pointer moves past it.
module rr_arbiter_burst #(
    parameter int N         = 4,
    parameter int MAX_BURST = 4,
    localparam int IDXW     = $clog2(N),
    localparam int CNTW     = $clog2(MAX_BURST + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    output logic [N-1:0]    grant,
    output logic            grant_valid,
    output logic [IDXW-1:0] grant_idx,
    output logic [CNTW-1:0] burst_cnt
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    localparam int unsigned     NU       = N;
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(MAX_BURST - 1);
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(N - 1);
    localparam logic [N-1:0]    ONE      = {{(N-1){1'b0}}, 1'b1};

    logic [0:0]      state, state_n;
    logic [IDXW-1:0] ptr, ptr_n;
    logic [IDXW-1:0] owner_inc;
    logic [N-1:0]    grant_n;
    logic [IDXW-1:0] idx_n;
    logic [CNTW-1:0] cnt_n;
    logic [IDXW:0]   hit_idle, hit_rel;
    logic            keep;

    // Returns {found, index} of the first request at or after p, wrapping mod N.
    function automatic logic [IDXW:0] search(input logic [N-1:0] r, input logic [IDXW-1:0] p);
        logic [IDXW:0] res;
        logic [N-1:0]  sh;
        int unsigned   j;
        res = '0;
        for (int unsigned i = 0; i < NU; i++) begin
            j = 32'(p) + i;
            if (j >= NU) j = j - NU;
            sh = r >> j;
            if (!res[IDXW] && sh[0]) res = {1'b1, IDXW'(j)};
        end
        return res;
    endfunction

    always_comb begin
        owner_inc = (grant_idx == IDX_LAST) ? '0 : grant_idx + IDXW'(1);
        hit_idle  = search(req, ptr);
        // The released owner is naturally last in line from owner_inc, so it only
        // wins again when it is the sole requester.
        hit_rel   = search(req, owner_inc);
        keep      = req[grant_idx] && (burst_cnt < CNT_LAST);

        state_n = state;
        ptr_n   = ptr;
        grant_n = grant;
        idx_n   = grant_idx;
        cnt_n   = burst_cnt;

        case (state)
            IDLE: begin
                if (hit_idle[IDXW]) begin
                    state_n = GRANT;
                    idx_n   = hit_idle[IDXW-1:0];
                    grant_n = ONE << hit_idle[IDXW-1:0];
                    cnt_n   = '0;
                end
            end
            GRANT: begin
                if (keep) begin
                    cnt_n = burst_cnt + CNTW'(1);
                end else begin
                    ptr_n = owner_inc;
                    cnt_n = '0;
                    if (hit_rel[IDXW]) begin
                        idx_n   = hit_rel[IDXW-1:0];
                        grant_n = ONE << hit_rel[IDXW-1:0];
                    end else begin
                        state_n = IDLE;
                        idx_n   = '0;
                        grant_n = '0;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                ptr_n   = '0;
                idx_n   = '0;
                grant_n = '0;
                cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_idx   <= '0;
            burst_cnt   <= '0;
        end else begin
            state       <= state_n;
            ptr         <= ptr_n;
            grant       <= grant_n;
            grant_valid <= |grant_n;
            grant_idx   <= idx_n;
            burst_cnt   <= cnt_n;
        end
    end

endmodule

// File: tb/tb_rr_arbiter_burst.sv
// Scoreboard bench for rr_arbiter_burst: a MAX_BURST=4 and a MAX_BURST=1 instance, N=4.
module tb_rr_arbiter_burst;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req, req1;
    logic [3:0] grant, grant1;
    logic       grant_valid, grant_valid1;
    logic [1:0] grant_idx, grant_idx1;
    logic [2:0] burst_cnt;
    logic [0:0] burst_cnt1;

    int unsigned vectors = 0;
    int unsigned errors  = 0;
    logic [9:0]  sbq[$];

    always #5 clk = ~clk;

    rr_arbiter_burst #(.N(4), .MAX_BURST(4)) dut (
        .clk(clk), .rst(rst), .req(req), .grant(grant),
        .grant_valid(grant_valid), .grant_idx(grant_idx), .burst_cnt(burst_cnt)
    );

    rr_arbiter_burst #(.N(4), .MAX_BURST(1)) dut1 (
        .clk(clk), .rst(rst), .req(req1), .grant(grant1),
        .grant_valid(grant_valid1), .grant_idx(grant_idx1), .burst_cnt(burst_cnt1)
    );

    // Packed expectation {grant, grant_valid, grant_idx, burst_cnt}.
    function automatic logic [9:0] mk(input logic [3:0] g, input logic [1:0] i, input logic [2:0] c);
        return {g, |g, i, c};
    endfunction

    task automatic reset_dut();
        rst  = 1'b1;
        req  = '0;
        req1 = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [9:0] e, o;
        rst = 1'b1; req = 4'b1111; req1 = 4'b1111;
        #1;
        sbq.push_back(mk(4'b0000, 2'd0, 3'd0));
        sbq.push_back(mk(4'b0000, 2'd0, 3'd0));
        @(posedge clk); #1;
        e = sbq.pop_front(); o = {grant, grant_valid, grant_idx, burst_cnt}; vectors++;
        if (o !== e) begin errors++; $display("FAIL reset dut got %b want %b", o, e); end
        e = sbq.pop_front(); o = {grant1, grant_valid1, grant_idx1, 3'(burst_cnt1)}; vectors++;
        if (o !== e) begin errors++; $display("FAIL reset dut1 got %b want %b", o, e); end
    endtask

    task automatic test_round_robin();
        logic [9:0] e, o;
        reset_dut();
        req = 4'b1111;
        for (int c = 0; c < 20; c++) begin
            sbq.push_back(mk(4'b0001 << ((c / 4) % 4), 2'((c / 4) % 4), 3'(c % 4)));
            @(posedge clk); #1;
            e = sbq.pop_front(); o = {grant, grant_valid, grant_idx, burst_cnt}; vectors++;
            if (o !== e) begin errors++; $display("FAIL round_robin c=%0d got %b want %b", c, o, e); end
            @(negedge clk);
        end
    endtask

    task automatic test_sole_requester();
        logic [9:0] e, o;
        reset_dut();
        req = 4'b0001;
        for (int c = 0; c < 10; c++) begin
            sbq.push_back(mk(4'b0001, 2'd0, 3'(c % 4)));
            @(posedge clk); #1;
            e = sbq.pop_front(); o = {grant, grant_valid, grant_idx, burst_cnt}; vectors++;
            if (o !== e) begin errors++; $display("FAIL sole c=%0d got %b want %b", c, o, e); end
            @(negedge clk);
        end
        // Release to idle, then all request: pointer sits at 1.
        req = 4'b0000;
        sbq.push_back(mk(4'b0000, 2'd0, 3'd0));
        @(posedge clk); #1;
        e = sbq.pop_front(); o = {grant, grant_valid, grant_idx, burst_cnt}; vectors++;
        if (o !== e) begin errors++; $display("FAIL sole_idle got %b want %b", o, e); end
        @(negedge clk);
        req = 4'b1111;
        sbq.push_back(mk(4'b0010, 2'd1, 3'd0));
        @(posedge clk); #1;
        e = sbq.pop_front(); o = {grant, grant_valid, grant_idx, burst_cnt}; vectors++;
        if (o !== e) begin errors++; $display("FAIL sole_ptr got %b want %b", o, e); end
        @(negedge clk);
    endtask

    task automatic test_early_release();
        logic [9:0] e, o;
        logic [3:0] rq[3];
        rq = '{4'b0110, 4'b0110, 4'b0100};
        reset_dut();
        sbq.push_back(mk(4'b0010, 2'd1, 3'd0));
        sbq.push_back(mk(4'b0010, 2'd1, 3'd1));
        sbq.push_back(mk(4'b0100, 2'd2, 3'd0));
        for (int c = 0; c < 3; c++) begin
            req = rq[c];
            @(posedge clk); #1;
            e = sbq.pop_front(); o = {grant, grant_valid, grant_idx, burst_cnt}; vectors++;
            if (o !== e) begin errors++; $display("FAIL early_release c=%0d got %b want %b", c, o, e); end
            @(negedge clk);
        end
    endtask

    task automatic test_idle_pointer();
        logic [9:0] e, o;
        logic [3:0] rq[5];
        rq = '{4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b1111};
        reset_dut();
        sbq.push_back(mk(4'b0100, 2'd2, 3'd0));
        sbq.push_back(mk(4'b0100, 2'd2, 3'd1));
        sbq.push_back(mk(4'b0000, 2'd0, 3'd0));
        sbq.push_back(mk(4'b0000, 2'd0, 3'd0));
        sbq.push_back(mk(4'b1000, 2'd3, 3'd0));
        for (int c = 0; c < 5; c++) begin
            req = rq[c];
            @(posedge clk); #1;
            e = sbq.pop_front(); o = {grant, grant_valid, grant_idx, burst_cnt}; vectors++;
            if (o !== e) begin errors++; $display("FAIL idle_pointer c=%0d got %b want %b", c, o, e); end
            @(negedge clk);
        end
    endtask

    task automatic test_async_reset();
        logic [9:0] e, o;
        reset_dut();
        req = 4'b0100;
        for (int c = 0; c < 3; c++) begin
            sbq.push_back(mk(4'b0100, 2'd2, 3'(c)));
            @(posedge clk); #1;
            e = sbq.pop_front(); o = {grant, grant_valid, grant_idx, burst_cnt}; vectors++;
            if (o !== e) begin errors++; $display("FAIL async_pre c=%0d got %b want %b", c, o, e); end
        end
        #2 rst = 1'b1;
        sbq.push_back(mk(4'b0000, 2'd0, 3'd0));
        #1;
        e = sbq.pop_front(); o = {grant, grant_valid, grant_idx, burst_cnt}; vectors++;
        if (o !== e) begin errors++; $display("FAIL async_reset got %b want %b", o, e); end
        @(negedge clk);
        rst = 1'b0;
        req = 4'b1111;
        sbq.push_back(mk(4'b0001, 2'd0, 3'd0));
        @(posedge clk); #1;
        e = sbq.pop_front(); o = {grant, grant_valid, grant_idx, burst_cnt}; vectors++;
        if (o !== e) begin errors++; $display("FAIL async_after got %b want %b", o, e); end
        @(negedge clk);
    endtask

    task automatic test_burst_one();
        logic [9:0] e, o;
        reset_dut();
        req1 = 4'b1010;
        for (int c = 0; c < 8; c++) begin
            if (c % 2 == 0) sbq.push_back(mk(4'b0010, 2'd1, 3'd0));
            else            sbq.push_back(mk(4'b1000, 2'd3, 3'd0));
            @(posedge clk); #1;
            e = sbq.pop_front(); o = {grant1, grant_valid1, grant_idx1, 3'(burst_cnt1)}; vectors++;
            if (o !== e) begin errors++; $display("FAIL burst_one c=%0d got %b want %b", c, o, e); end
            @(negedge clk);
        end
        req1 = '0;
    endtask

    initial begin
        rst = 1'b1; req = '0; req1 = '0;
        test_reset();
        test_round_robin();
        test_sole_requester();
        test_early_release();
        test_idle_pointer();
        test_async_reset();
        test_burst_one();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/rr_arbiter_burst.md
Name: rr_arbiter_burst

Overview:
- Parametrised N-way round-robin arbiter for the memory controller's request path. Successor to the fixed 4-way arbiter.
- Adds three things the 4-way block lacks: configurable requester count, true round-robin (the pointer advances past the last owner), and burst holding.
- Burst holding: an owner keeps the grant for up to MAX_BURST consecutive cycles while its request stays high.
- Sits between requesters (DMA/CPU ports) and the command scheduler. Grant is registered.

Parameters:
- N, 4, number of requesters; legal range 2..32.
- MAX_BURST, 4, maximum consecutive cycles one owner may hold the grant; must be >= 1. A value of 1 means rotate every cycle.
- IDXW, $clog2(N), width of grant_idx (derived, not overridden).
- CNTW, $clog2(MAX_BURST+1), width of the burst counter (derived).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  N  request lines; req[i]=1 means requester i wants the resource.
- grant  output  N  registered one-hot grant; all zeros when idle.
- grant_valid  output  1  registered; equals |grant.
- grant_idx  output  IDXW  registered binary index of the current owner; 0 when idle.
- burst_cnt  output  CNTW  registered count of cycles the owner has held the grant so far, 0-based.

Behaviour:
- Reset (async, rst=1): grant=0, grant_valid=0, grant_idx=0, burst_cnt=0, pointer=0, state=IDLE. Applies immediately, including mid-burst.
- Internal state: pointer (IDXW bits), owner, burst counter, FSM {IDLE, GRANT}.
- Search function: first i with req[i]=1, scanning pointer, pointer+1, ..., N-1, 0, ..., pointer-1 (wrap mod N).
- IDLE:
  - If any req at a rising edge, then at that edge: grant one-hot at search result k, grant_idx=k, burst_cnt=0, go to GRANT.
  - Latency from req to grant is 1 cycle.
  - No req: remain IDLE, outputs 0.
- GRANT with owner k, evaluated at each rising edge using the req sampled at that edge:
  - Continue: req[k]=1 and burst_cnt < MAX_BURST-1. Grant unchanged; burst_cnt increments by 1.
  - Release: req[k]=0, or burst_cnt == MAX_BURST-1. Then at the same edge:
    - pointer <= (k+1) mod N.
    - Re-search with the new pointer, excluding k when req[k]=0.
    - If a winner j exists: grant moves directly to j, burst_cnt=0. No dead cycle between owners.
    - If no winner: grant=0, grant_idx=0, burst_cnt=0, go to IDLE.
  - Quota expiry with k the only requester: k is re-granted immediately (it is lowest priority but the sole candidate) with burst_cnt=0, no gap.
- Pointer wrap: pointer N-1 advances to 0.
- Pointer changes only on release. It is never changed in IDLE and never changed without a grant.
- Non-owner request changes during GRANT have no effect until release.
- Invariants: grant is always one-hot or zero; grant_valid == |grant; grant_idx == encode(grant) whenever grant_valid=1.
- Deasserting rst: the arbiter starts in IDLE, and the first grant can appear at the first rising edge after rst falls.

Test Plan:
All cases use N=4, MAX_BURST=4 unless stated. Edge E1 is the first rising edge after rst drops with req applied.

1. req=1111 held 20 cycles -> grant sequence 0001 x4, 0010 x4, 0100 x4, 1000 x4, 0001..., burst_cnt 0,1,2,3 repeating, no zero cycles.
2. req=0001 held 10 cycles -> grant=0001 every cycle from E1; burst_cnt 0..3 then back to 0 at E5 with no gap; pointer=1 after E5.
3. req=0110 -> grant 0010 at E1; req[1] dropped before E3 -> grant 0100 at E3, burst_cnt=0, grant_idx=2.
4. req=0100 for 2 cycles then 0000 -> grant 0100 at E1..E2, then 0000 with grant_valid=0. Then req=1111 -> next grant 1000 (pointer=3).
5. rst pulsed while owner 2 is at burst_cnt=2 -> grant=0000 and burst_cnt=0 immediately, before any clock edge. After release with req=1111 -> grant 0001 at the first edge.
6. MAX_BURST=1 instance, req=1010 held -> grant alternates 0010, 1000, 0010, 1000; burst_cnt stays 0.
